// File: rtl/hazard3_cdc_req_src_pkg.sv
// ============================================================================
// hazard3_cdc_req_src_pkg
// State encodings shared by the four-phase CDC request source.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hazard3_cdc_req_src_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RSVD    = 2'd3
  } state_e;

  // The unused code behaves exactly like IDLE so a corrupted state self-recovers.
  function automatic logic st_is_idle(input state_e s);
    return (s == ST_IDLE) || (s == ST_RSVD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard3_sync_1bit.sv
// ============================================================================
// hazard3_sync_1bit
// Multi-flop synchronizer for a single asynchronous level signal.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard3_sync_1bit #(
  parameter int N_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [N_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[N_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[N_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/hazard3_cdc_req_src.sv
// ============================================================================
// hazard3_cdc_req_src
// Source endpoint of a four-phase req/ack crossing holding a quasi-static word.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard3_cdc_req_src
  import hazard3_cdc_req_src_pkg::*;
#(
  parameter int W      = 32,
  parameter int N_SYNC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         src_valid,
  output logic         src_ready,
  input  logic [W-1:0] src_data,
  output logic         req_o,
  output logic [W-1:0] data_o,
  input  logic         ack_i,
  output logic         busy
);

  state_e       r_state;
  logic         r_req;
  logic [W-1:0] r_data;
  logic         w_ack_s;
  logic         w_rst_n;
  logic         w_idle;

  assign w_rst_n = !rst;

  hazard3_sync_1bit #(
    .N_STAGES (N_SYNC)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (w_rst_n),
    .i_d   (ack_i),
    .o_q   (w_ack_s)
  );

  assign w_idle = st_is_idle(r_state);

  // A still-high ack in IDLE means the far side has not finished a previous
  // handshake; accepting now would pair our new req with its stale ack.
  assign src_ready = w_idle && !w_ack_s;
  assign busy      = !w_idle;
  assign req_o     = r_req;
  assign data_o    = r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_ack_s) begin
            r_req   <= 1'b0;
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!w_ack_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          if (src_valid && !w_ack_s) begin
            r_data  <= src_data;
            r_req   <= 1'b1;
            r_state <= ST_REQ;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard3_cdc_req_src.sv
// ============================================================================
// tb_hazard3_cdc_req_src
// Directed bench for the four-phase CDC request source (W=32, N_SYNC=2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard3_cdc_req_src;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        src_valid = 1'b0;
  logic        src_ready;
  logic [31:0] src_data = '0;
  logic        req_o;
  logic [31:0] data_o;
  logic        ack_i = 1'b0;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  hazard3_cdc_req_src #(
    .W      (32),
    .N_SYNC (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_data  (src_data),
    .req_o     (req_o),
    .data_o    (data_o),
    .ack_i     (ack_i),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance across one rising edge; outputs are sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] seen [0:3];
    int          nh;
    int          cyc;
    logic        prev_req;
    logic        ok;
    int          dly;

    // Reset release, idle
    rst = 1'b1;
    step(); step();
    chk("rst_req", {31'd0, req_o}, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_ready", {31'd0, src_ready}, 32'd1);
    chk("idle_req",   {31'd0, req_o},     32'd0);
    chk("idle_data",  data_o,             32'd0);
    chk("idle_busy",  {31'd0, busy},      32'd0);

    // Single transfer with hand-timed ack
    src_data  = 32'hDEADBEEF;
    src_valid = 1'b1;
    step();
    src_valid = 1'b0;
    src_data  = 32'h12345678;
    chk("acc_req",   {31'd0, req_o},     32'd1);
    chk("acc_data",  data_o,             32'hDEADBEEF);
    chk("acc_busy",  {31'd0, busy},      32'd1);
    chk("acc_ready", {31'd0, src_ready}, 32'd0);
    step(); step();
    ack_i = 1'b1;
    step();
    chk("a0_req", {31'd0, req_o}, 32'd1);
    step();
    chk("a1_req", {31'd0, req_o}, 32'd1);
    step();
    chk("a2_req_fall", {31'd0, req_o},     32'd0);
    chk("a2_busy",     {31'd0, busy},      32'd1);
    chk("a2_ready",    {31'd0, src_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rel_ready", {31'd0, src_ready}, 32'd0);
      chk("rel_data",  data_o,             32'hDEADBEEF);
    end
    ack_i = 1'b0;
    step();
    chk("b0_ready", {31'd0, src_ready}, 32'd0);
    step();
    chk("b1_ready", {31'd0, src_ready}, 32'd0);
    chk("b1_busy",  {31'd0, busy},      32'd1);
    step();
    chk("b2_ready", {31'd0, src_ready}, 32'd1);
    chk("b2_busy",  {31'd0, busy},      32'd0);
    chk("b2_data",  data_o,             32'hDEADBEEF);

    // Back-to-back stream 1,2,3 with an auto-acking destination
    nh        = 0;
    prev_req  = 1'b0;
    src_data  = 32'd1;
    src_valid = 1'b1;
    cyc       = 0;
    while (!(nh == 3 && !busy) && cyc < 200) begin
      step();
      cyc++;
      if (req_o && !prev_req) begin
        if (nh < 4) seen[nh] = data_o;
        nh++;
        src_data = 32'(nh + 1);
        if (nh == 3) src_valid = 1'b0;
      end
      prev_req = req_o;
      ack_i    = req_o;
    end
    chk("b2b_timeout", {31'd0, (cyc >= 200)}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (req_o && !prev_req) nh++;
      prev_req = req_o;
      ack_i    = req_o;
    end
    ack_i = 1'b0;
    chk("b2b_count", 32'(nh), 32'd3);
    chk("b2b_d0", seen[0], 32'd1);
    chk("b2b_d1", seen[1], 32'd2);
    chk("b2b_d2", seen[2], 32'd3);

    // Stale ack across reset release
    rst   = 1'b1;
    ack_i = 1'b1;
    step(); step();
    rst = 1'b0;
    step(); step();
    src_data  = 32'hAAAA5555;
    src_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stale_ready", {31'd0, src_ready}, 32'd0);
      chk("stale_req",   {31'd0, req_o},     32'd0);
      chk("stale_busy",  {31'd0, busy},      32'd0);
    end
    ack_i = 1'b0;
    step();
    chk("stale_f1_ready", {31'd0, src_ready}, 32'd0);
    step();
    chk("stale_f2_ready", {31'd0, src_ready}, 32'd1);
    step();
    src_valid = 1'b0;
    chk("stale_acc_req",  {31'd0, req_o}, 32'd1);
    chk("stale_acc_data", data_o,         32'hAAAA5555);

    // Reset mid-transfer: req_o drops without a clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_req",  {31'd0, req_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy},  32'd0);
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_idle",  {31'd0, busy},      32'd0);
    chk("mid_rst_ready", {31'd0, src_ready}, 32'd1);
    chk("mid_rst_data",  data_o,             32'd0);

    // Random ack delays; data must stay put while the transfer is open
    for (int k = 0; k < 4; k++) begin
      src_data  = 32'h100 + 32'(k);
      src_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        step();
        ok = req_o;
      end
      src_valid = 1'b0;
      chk("rnd_req_rise", {31'd0, ok}, 32'd1);
      dly = $urandom_range(0, 4);
      for (int i = 0; i < dly; i++) begin
        step();
        chk("rnd_hold_req", {31'd0, req_o}, 32'd1);
      end
      ack_i = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        step();
        chk("rnd_stable", data_o, 32'h100 + 32'(k));
        ok = !req_o;
      end
      chk("rnd_req_fall", {31'd0, ok}, 32'd1);
      dly = $urandom_range(0, 4);
      for (int i = 0; i < dly; i++) begin
        step();
        chk("rnd_rel_req", {31'd0, req_o}, 32'd0);
      end
      ack_i = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        step();
        chk("rnd_rel_data", data_o, 32'h100 + 32'(k));
        ok = !busy;
      end
      chk("rnd_idle", {31'd0, ok}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
